calc_entry: RTL and testbench
=============================

# calc_entry

Sequential keypad-entry controller that builds the two BCD operands and operator for the combinational `Calculate` core, then captures its outcome. It sits between the keypad decoder and `Calculate`. It drives `operand1`, `operand2` and `switches` into `Calculate` and latches `result`, `mod`, `negative`, `overflow` and `error` back for display. Operands are packed BCD, `DIGITS` digits each, right-aligned in 32 bits; upper unused bits are zero.

## Interface

Parameters:
- `DIGITS`, default 4: maximum BCD digits per operand (1–8).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid with it.
- `key_code`  in  4  0–9 digit; A add; B subtract; C multiply; D divide; E equals; F clear.
- `operand1`  out  32  BCD operand 1 to `Calculate`.
- `operand2`  out  32  BCD operand 2 to `Calculate`.
- `switches`  out  2  operator select: 0 add, 1 sub, 2 mul, 3 div.
- `result`, `mod`  in  32 each  from `Calculate`.
- `negative`, `overflow`, `error`  in  1 each  from `Calculate`.
- `disp_value`  out  32  value to show.
- `disp_mod`  out  32  latched remainder.
- `disp_neg`, `disp_ovf`, `disp_err`  out  1 each  latched flags.
- `calc_done`  out  1  one-cycle pulse when a result is latched.
- `state`  out  2  current FSM state, for debug.

## Operation

FSM states: ENTER1 (0), ENTER2 (1), EVAL (2), SHOW (3). Reset or clear key (F, any state) puts the block in ENTER1 and zeroes all registers. `cnt1` and `cnt2` count entered digits per operand.

ENTER1:
- Digit key with `cnt1<DIGITS`: `operand1 <= {operand1, digit}` within 4*DIGITS bits, `cnt1++`.
- Digit key with `cnt1=DIGITS`: ignored.
- Operator key A–D: `switches <= code-A`, `operand2 <= 0`, `cnt2 <= 0`, go ENTER2.
- E: ignored.

ENTER2:
- Digit key: shifts into `operand2`, with the same `DIGITS` limit as ENTER1.
- Operator key: replaces `switches`.
- E: go EVAL. `operand2` may be 0; division by zero is flagged by `Calculate`, not here.

EVAL:
- Lasts exactly one cycle; all keys are ignored.
- Latches `disp_value<=result`, `disp_mod<=mod`, `disp_neg<=negative`, `disp_ovf<=overflow`, `disp_err<=error`.
- Then goes to SHOW.

SHOW:
- Digit key: `operand1 <= digit`, `cnt1 <= 1`, `operand2 <= 0`, clear the disp flags, go ENTER1.
- Operator key when `disp_neg|disp_ovf|disp_err = 0`: chain. `operand1 <= disp_value`, `cnt1 <= DIGITS`, set `switches`, `operand2 <= 0`, go ENTER2.
- Operator key when any of those flags is set: ignored.
- E: ignored.

`disp_value` is combinational from registers:
- ENTER1: `operand1`.
- ENTER2: `operand2` when `cnt2>0`, else `operand1`.
- EVAL/SHOW: latched result register.

## Timing

- `key_valid` is sampled on the rising edge. Its effect is visible on outputs the following cycle.
- `Calculate` is combinational. `operand1`/`operand2`/`switches` are stable for the whole EVAL cycle; the result is sampled at the edge ending EVAL.
- Latency from E at edge N: EVAL during cycle N+1, SHOW from N+2. `calc_done` is high for exactly cycle N+2 and is registered.
- Reset values: all outputs 0, `state=ENTER1`, `calc_done=0`.
- Reset mid-operation, including during EVAL: immediate asynchronous return to reset values. No result is latched and there is no `calc_done`.
- Back-to-back `key_valid` on consecutive cycles is legal; each key is processed. A key arriving in EVAL is dropped.
- Clear (F) takes priority over every other action and is itself effective at the next edge.

## Test plan

- Keys 1,9,4,9,A,2,8,1,8,E → `operand1=0x1949`, `operand2=0x2818`, `switches=0`. Two cycles after E: `disp_value=0x4767`, `disp_ovf=0`, `calc_done` pulses once.
- Keys 9,8,8,9,A,8,9,9,7,E → `disp_ovf=1`. A following A is ignored: `state` stays 3 and `operand1` is unchanged.
- Keys 1,2,3,7,B,2,1,3,0,E → `switches=1`, `disp_neg=1`, `disp_value=0x0893`. Then digit 5 → `state=0`, `operand1=0x0005`, all disp flags 0.
- Keys 2,5,5,6,D,2,3,E → `disp_value=0x0111`, `disp_mod=0x0003`.
- Keys 1,2,3,4,5 → `operand1=0x1234` (fifth digit dropped). Then F → all zero. Then 1,4,2,5,D,E → `disp_err=1`.
- Keys 1,3,7,C,5,3,E → `0x7261`. Then A,1,E → `operand1=0x7261`, `disp_value=0x7262`.
- Pulse `rst_n` low during ENTER2 → every output 0 immediately.

Source files
------------

// File: rtl/calc_entry.sv
`default_nettype none
// ============================================================================
//  Module      : calc_entry
//  Description : Keypad-entry controller. Builds two packed-BCD operands and
//                an operator for the combinational Calculate core, then
//                latches the outcome for display.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_entry #(
    parameter int DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [1:0]  switches,
    input  logic [31:0] result,
    input  logic [31:0] mod,
    input  logic        negative,
    input  logic        overflow,
    input  logic        error,
    output logic [31:0] disp_value,
    output logic [31:0] disp_mod,
    output logic        disp_neg,
    output logic        disp_ovf,
    output logic        disp_err,
    output logic        calc_done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_ENTER1 = 2'd0,
        ST_ENTER2 = 2'd1,
        ST_EVAL   = 2'd2,
        ST_SHOW   = 2'd3
    } state_t;

    // Keeps shifted operands inside the DIGITS nibbles they may occupy
    localparam logic [31:0] c_mask    = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);
    localparam logic [3:0]  c_max_cnt = 4'(DIGITS);

    state_t      r_state, w_nxt_state;
    logic [31:0] r_op1, w_nxt_op1;
    logic [31:0] r_op2, w_nxt_op2;
    logic [1:0]  r_sw, w_nxt_sw;
    logic [3:0]  r_cnt1, w_nxt_cnt1;
    logic [3:0]  r_cnt2, w_nxt_cnt2;
    logic [31:0] r_res, w_nxt_res;
    logic [31:0] r_mod, w_nxt_mod;
    logic        r_neg, w_nxt_neg;
    logic        r_ovf, w_nxt_ovf;
    logic        r_err, w_nxt_err;
    logic        r_done, w_nxt_done;

    logic        w_digit, w_oper, w_equal, w_clear;
    logic [1:0]  w_op_sel;
    logic [31:0] w_shift1, w_shift2;
    logic        w_any_flag;

    assign w_digit    = key_valid && (key_code <= 4'd9);
    assign w_oper     = key_valid && (key_code >= 4'hA) && (key_code <= 4'hD);
    assign w_equal    = key_valid && (key_code == 4'hE);
    assign w_clear    = key_valid && (key_code == 4'hF);
    // A..D map to 0..3; subtracting 0xA modulo 4 only flips bit 1
    assign w_op_sel   = key_code[1:0] ^ 2'b10;
    assign w_shift1   = ((r_op1 << 4) | {28'd0, key_code}) & c_mask;
    assign w_shift2   = ((r_op2 << 4) | {28'd0, key_code}) & c_mask;
    assign w_any_flag = r_neg | r_ovf | r_err;

    // State register and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTER1;
            r_op1   <= '0;
            r_op2   <= '0;
            r_sw    <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_res   <= '0;
            r_mod   <= '0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_op1   <= w_nxt_op1;
            r_op2   <= w_nxt_op2;
            r_sw    <= w_nxt_sw;
            r_cnt1  <= w_nxt_cnt1;
            r_cnt2  <= w_nxt_cnt2;
            r_res   <= w_nxt_res;
            r_mod   <= w_nxt_mod;
            r_neg   <= w_nxt_neg;
            r_ovf   <= w_nxt_ovf;
            r_err   <= w_nxt_err;
            r_done  <= w_nxt_done;
        end
    end

    // Next-state and key handling; clear overrides everything else
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_op1   = r_op1;
        w_nxt_op2   = r_op2;
        w_nxt_sw    = r_sw;
        w_nxt_cnt1  = r_cnt1;
        w_nxt_cnt2  = r_cnt2;
        w_nxt_res   = r_res;
        w_nxt_mod   = r_mod;
        w_nxt_neg   = r_neg;
        w_nxt_ovf   = r_ovf;
        w_nxt_err   = r_err;
        w_nxt_done  = 1'b0;

        if (w_clear) begin
            w_nxt_state = ST_ENTER1;
            w_nxt_op1   = '0;
            w_nxt_op2   = '0;
            w_nxt_sw    = '0;
            w_nxt_cnt1  = '0;
            w_nxt_cnt2  = '0;
            w_nxt_res   = '0;
            w_nxt_mod   = '0;
            w_nxt_neg   = 1'b0;
            w_nxt_ovf   = 1'b0;
            w_nxt_err   = 1'b0;
        end else begin
            case (r_state)
                ST_ENTER1: begin
                    if (w_digit && (r_cnt1 < c_max_cnt)) begin
                        w_nxt_op1  = w_shift1;
                        w_nxt_cnt1 = r_cnt1 + 4'd1;
                    end else if (w_oper) begin
                        w_nxt_sw    = w_op_sel;
                        w_nxt_op2   = '0;
                        w_nxt_cnt2  = '0;
                        w_nxt_state = ST_ENTER2;
                    end
                end
                ST_ENTER2: begin
                    if (w_digit && (r_cnt2 < c_max_cnt)) begin
                        w_nxt_op2  = w_shift2;
                        w_nxt_cnt2 = r_cnt2 + 4'd1;
                    end else if (w_oper) begin
                        w_nxt_sw = w_op_sel;
                    end else if (w_equal) begin
                        w_nxt_state = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // Operands have been stable all cycle; sample the core
                    w_nxt_res   = result;
                    w_nxt_mod   = mod;
                    w_nxt_neg   = negative;
                    w_nxt_ovf   = overflow;
                    w_nxt_err   = error;
                    w_nxt_done  = 1'b1;
                    w_nxt_state = ST_SHOW;
                end
                ST_SHOW: begin
                    if (w_digit) begin
                        w_nxt_op1   = {28'd0, key_code};
                        w_nxt_cnt1  = 4'd1;
                        w_nxt_op2   = '0;
                        w_nxt_cnt2  = '0;
                        w_nxt_neg   = 1'b0;
                        w_nxt_ovf   = 1'b0;
                        w_nxt_err   = 1'b0;
                        w_nxt_state = ST_ENTER1;
                    end else if (w_oper && !w_any_flag) begin
                        // Chain: the shown result becomes the new first operand
                        w_nxt_op1   = r_res;
                        w_nxt_cnt1  = c_max_cnt;
                        w_nxt_sw    = w_op_sel;
                        w_nxt_op2   = '0;
                        w_nxt_cnt2  = '0;
                        w_nxt_state = ST_ENTER2;
                    end
                end
                default: w_nxt_state = ST_ENTER1;
            endcase
        end
    end

    // Display mux: show whichever operand is being typed, else the result
    always_comb begin
        disp_value = r_res;
        case (r_state)
            ST_ENTER1: disp_value = r_op1;
            ST_ENTER2: disp_value = (r_cnt2 != 4'd0) ? r_op2 : r_op1;
            default:   disp_value = r_res;
        endcase
    end

    assign operand1  = r_op1;
    assign operand2  = r_op2;
    assign switches  = r_sw;
    assign disp_mod  = r_mod;
    assign disp_neg  = r_neg;
    assign disp_ovf  = r_ovf;
    assign disp_err  = r_err;
    assign calc_done = r_done;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_entry
//  Description : Self-checking bench for calc_entry with a behavioural
//                Calculate stand-in and a decimal-valued reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_entry;

    localparam int D = 4;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] md;
        logic        neg;
        logic        ovf;
        logic        err;
    } calc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] operand1, operand2, result, mod, disp_value, disp_mod;
    logic [1:0]  switches, state;
    logic        negative, overflow, error;
    logic        disp_neg, disp_ovf, disp_err, calc_done;

    int checks = 0;
    int passes = 0;

    // Reference model state: operands held as plain decimal integers
    longint m_op1, m_op2;
    int     m_sw, m_cnt1, m_cnt2, m_st;
    logic [31:0] m_val, m_md;
    bit     m_neg, m_ovf, m_err, m_done;

    calc_entry #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .operand1(operand1), .operand2(operand2), .switches(switches),
        .result(result), .mod(mod), .negative(negative), .overflow(overflow),
        .error(error), .disp_value(disp_value), .disp_mod(disp_mod),
        .disp_neg(disp_neg), .disp_ovf(disp_ovf), .disp_err(disp_err),
        .calc_done(calc_done), .state(state)
    );

    always #5 clk = ~clk;

    function automatic longint from_bcd(input logic [31:0] b);
        longint v = 0;
        for (int i = 7; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(input longint v);
        logic [31:0] b = '0;
        longint t = v;
        for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    // Decimal arithmetic on D-digit magnitudes
    function automatic calc_t calc(input longint a, input longint b, input int sw);
        calc_t  c = '0;
        longint lim = 1;
        longint r = 0, m = 0;
        for (int i = 0; i < D; i++) lim = lim * 10;
        case (sw)
            0: r = a + b;
            1: if (a < b) begin c.neg = 1'b1; r = b - a; end else r = a - b;
            2: r = a * b;
            default: if (b == 0) c.err = 1'b1; else begin r = a / b; m = a % b; end
        endcase
        if (r >= lim) begin c.ovf = 1'b1; r = r % lim; end
        c.res = to_bcd(r);
        c.md  = to_bcd(m);
        return c;
    endfunction

    // Combinational Calculate stand-in driven by the DUT's operand outputs
    always_comb begin
        calc_t c;
        c = calc(from_bcd(operand1), from_bcd(operand2), int'(switches));
        result   = c.res;
        mod      = c.md;
        negative = c.neg;
        overflow = c.ovf;
        error    = c.err;
    end

    task automatic model_reset();
        m_op1 = 0; m_op2 = 0; m_sw = 0; m_cnt1 = 0; m_cnt2 = 0; m_st = 0;
        m_val = '0; m_md = '0; m_neg = 0; m_ovf = 0; m_err = 0; m_done = 0;
    endtask

    // Advance the model by one clock edge given the key seen at that edge
    task automatic model_edge(input bit v, input logic [3:0] k);
        bit dig, opk, eq;
        calc_t c;
        dig = v && (k <= 9);
        opk = v && (k >= 10) && (k <= 13);
        eq  = v && (k == 14);
        if (v && k == 15) begin model_reset(); return; end
        m_done = 0;
        case (m_st)
            0: if (dig && m_cnt1 < D) begin m_op1 = m_op1 * 10 + k; m_cnt1++; end
               else if (opk) begin m_sw = k - 10; m_op2 = 0; m_cnt2 = 0; m_st = 1; end
            1: if (dig && m_cnt2 < D) begin m_op2 = m_op2 * 10 + k; m_cnt2++; end
               else if (opk) m_sw = k - 10;
               else if (eq) m_st = 2;
            2: begin
                c = calc(m_op1, m_op2, m_sw);
                m_val = c.res; m_md = c.md; m_neg = c.neg; m_ovf = c.ovf; m_err = c.err;
                m_done = 1; m_st = 3;
            end
            default: if (dig) begin
                    m_op1 = k; m_cnt1 = 1; m_op2 = 0; m_cnt2 = 0;
                    m_neg = 0; m_ovf = 0; m_err = 0; m_st = 0;
                end else if (opk && !(m_neg || m_ovf || m_err)) begin
                    m_op1 = from_bcd(m_val); m_cnt1 = D; m_sw = k - 10;
                    m_op2 = 0; m_cnt2 = 0; m_st = 1;
                end
        endcase
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        model_edge(1'b1, k);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle();
        @(posedge clk);
        model_edge(1'b0, 4'h0);
        #1;
    endtask

    task automatic keys(input logic [3:0] seq [$]);
        foreach (seq[i]) press(seq[i]);
    endtask

    task automatic test_reset();
        logic [135:0] obs;
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        model_reset();
        #12;
        obs = {operand1, operand2, switches, disp_value, disp_mod,
               disp_neg, disp_ovf, disp_err, calc_done, state};
        checks++; if (obs !== '0) $display("FAIL reset_outputs: got %h exp 0", obs); else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        keys('{4'hF, 1, 9, 4, 9, 4'hA, 2, 8, 1, 8});
        checks++; if (operand1 !== 32'h1949) $display("FAIL add_op1: got %h exp 1949", operand1); else passes++;
        checks++; if (operand2 !== 32'h2818) $display("FAIL add_op2: got %h exp 2818", operand2); else passes++;
        checks++; if (switches !== 2'd0) $display("FAIL add_sw: got %0d exp 0", switches); else passes++;
        press(4'hE);
        checks++; if (state !== 2'd2 || calc_done !== 1'b0) $display("FAIL add_eval: state %0d done %b exp 2/0", state, calc_done); else passes++;
        idle();
        checks++; if (disp_value !== 32'h4767) $display("FAIL add_value: got %h exp 4767", disp_value); else passes++;
        checks++; if (disp_ovf !== 1'b0) $display("FAIL add_ovf: got %b exp 0", disp_ovf); else passes++;
        checks++; if (calc_done !== 1'b1 || state !== 2'd3) $display("FAIL add_done: done %b state %0d exp 1/3", calc_done, state); else passes++;
        idle();
        checks++; if (calc_done !== 1'b0) $display("FAIL add_done_once: got %b exp 0", calc_done); else passes++;
    endtask

    task automatic test_overflow();
        keys('{4'hF, 9, 8, 8, 9, 4'hA, 8, 9, 9, 7, 4'hE});
        idle();
        checks++; if (disp_ovf !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", disp_ovf); else passes++;
        press(4'hA);
        checks++; if (state !== 2'd3) $display("FAIL ovf_chain_state: got %0d exp 3", state); else passes++;
        checks++; if (operand1 !== 32'h9889) $display("FAIL ovf_chain_op1: got %h exp 9889", operand1); else passes++;
    endtask

    task automatic test_sub_restart();
        keys('{4'hF, 1, 2, 3, 7, 4'hB, 2, 1, 3, 0});
        checks++; if (switches !== 2'd1) $display("FAIL sub_sw: got %0d exp 1", switches); else passes++;
        press(4'hE);
        idle();
        checks++; if (disp_neg !== 1'b1) $display("FAIL sub_neg: got %b exp 1", disp_neg); else passes++;
        checks++; if (disp_value !== 32'h0893) $display("FAIL sub_value: got %h exp 0893", disp_value); else passes++;
        press(4'd5);
        checks++; if (state !== 2'd0 || operand1 !== 32'h5) $display("FAIL restart: state %0d op1 %h exp 0/5", state, operand1); else passes++;
        checks++; if ({disp_neg, disp_ovf, disp_err} !== 3'b000) $display("FAIL restart_flags: got %b exp 000", {disp_neg, disp_ovf, disp_err}); else passes++;
    endtask

    task automatic test_div();
        keys('{4'hF, 2, 5, 5, 6, 4'hD, 2, 3, 4'hE});
        idle();
        checks++; if (disp_value !== 32'h0111) $display("FAIL div_quot: got %h exp 0111", disp_value); else passes++;
        checks++; if (disp_mod !== 32'h0003) $display("FAIL div_mod: got %h exp 0003", disp_mod); else passes++;
    endtask

    task automatic test_limit_clear_div0();
        logic [135:0] obs;
        keys('{4'hF, 1, 2, 3, 4, 5});
        checks++; if (operand1 !== 32'h1234) $display("FAIL digit_limit: got %h exp 1234", operand1); else passes++;
        press(4'hF);
        obs = {operand1, operand2, switches, disp_value, disp_mod,
               disp_neg, disp_ovf, disp_err, calc_done, state};
        checks++; if (obs !== '0) $display("FAIL clear_all: got %h exp 0", obs); else passes++;
        keys('{1, 4, 2, 5, 4'hD, 4'hE});
        idle();
        checks++; if (disp_err !== 1'b1) $display("FAIL div0_err: got %b exp 1", disp_err); else passes++;
    endtask

    task automatic test_chain();
        keys('{4'hF, 1, 3, 7, 4'hC, 5, 3, 4'hE});
        idle();
        checks++; if (disp_value !== 32'h7261) $display("FAIL mul_value: got %h exp 7261", disp_value); else passes++;
        keys('{4'hA, 1, 4'hE});
        idle();
        checks++; if (operand1 !== 32'h7261) $display("FAIL chain_op1: got %h exp 7261", operand1); else passes++;
        checks++; if (disp_value !== 32'h7262) $display("FAIL chain_value: got %h exp 7262", disp_value); else passes++;
    endtask

    // Random keys, mostly back-to-back, compared against the model every cycle
    task automatic test_back_to_back();
        logic [31:0] exp_val;
        int r;
        logic [3:0] k;
        press(4'hF);
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) idle();
            else begin
                if (r < 55)      k = 4'($urandom_range(0, 9));
                else if (r < 75) k = 4'($urandom_range(10, 13));
                else if (r < 95) k = 4'hE;
                else             k = (m_st == 2) ? 4'hE : 4'hF;
                press(k);
            end
            if (m_st == 0)      exp_val = to_bcd(m_op1);
            else if (m_st == 1) exp_val = (m_cnt2 > 0) ? to_bcd(m_op2) : to_bcd(m_op1);
            else                exp_val = m_val;
            checks++; if (state !== 2'(m_st)) $display("FAIL rnd_state n=%0d: got %0d exp %0d", n, state, m_st); else passes++;
            checks++; if (operand1 !== to_bcd(m_op1)) $display("FAIL rnd_op1 n=%0d: got %h exp %h", n, operand1, to_bcd(m_op1)); else passes++;
            checks++; if (operand2 !== to_bcd(m_op2)) $display("FAIL rnd_op2 n=%0d: got %h exp %h", n, operand2, to_bcd(m_op2)); else passes++;
            checks++; if (switches !== 2'(m_sw)) $display("FAIL rnd_sw n=%0d: got %0d exp %0d", n, switches, m_sw); else passes++;
            checks++; if (disp_value !== exp_val) $display("FAIL rnd_value n=%0d: got %h exp %h", n, disp_value, exp_val); else passes++;
            checks++; if (disp_mod !== m_md) $display("FAIL rnd_mod n=%0d: got %h exp %h", n, disp_mod, m_md); else passes++;
            checks++; if ({disp_neg, disp_ovf, disp_err} !== {m_neg, m_ovf, m_err}) $display("FAIL rnd_flags n=%0d: got %b exp %b", n, {disp_neg, disp_ovf, disp_err}, {m_neg, m_ovf, m_err}); else passes++;
            checks++; if (calc_done !== m_done) $display("FAIL rnd_done n=%0d: got %b exp %b", n, calc_done, m_done); else passes++;
        end
    endtask

    task automatic test_reset_midop();
        logic [135:0] obs;
        keys('{4'hF, 1, 2, 4'hA, 3});
        checks++; if (state !== 2'd1) $display("FAIL midop_pre: got %0d exp 1", state); else passes++;
        #2 rst_n = 1'b0;
        #1;
        obs = {operand1, operand2, switches, disp_value, disp_mod,
               disp_neg, disp_ovf, disp_err, calc_done, state};
        checks++; if (obs !== '0) $display("FAIL midop_reset: got %h exp 0", obs); else passes++;
        #1 rst_n = 1'b1;
        model_reset();
        press(4'd7);
        checks++; if (operand1 !== 32'h7 || state !== 2'd0) $display("FAIL post_reset: op1 %h state %0d exp 7/0", operand1, state); else passes++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub_restart();
        test_div();
        test_limit_clear_div0();
        test_chain();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
